// File: rtl/adc_ro_pkg.sv
// rtl/adc_ro_pkg.sv - shared types and constants for the column-ADC row readout
// Contents: one-hot sequencer state enum, default geometry, timing clamp minimums,
// and a small clamp helper used when latching the programmed widths.
package adc_ro_pkg;

    localparam int N_BITS_DEF = 12;
    localparam int N_CH_DEF   = 17;

    localparam int LTCH_MIN  = 1;
    localparam int DV_HI_MIN = 2;
    localparam int DV_LO_MIN = 1;

    // One-hot, 32-bit wide to match the state encoding used by the other ADC blocks.
    typedef enum logic [31:0] {
        S_IDLE  = 32'h0000_0001,
        S_LATCH = 32'h0000_0002,
        S_GAP   = 32'h0000_0004,
        S_DV_HI = 32'h0000_0008,
        S_DV_LO = 32'h0000_0010,
        S_PUSH  = 32'h0000_0020,
        S_DONE  = 32'h0000_0040
    } ro_state_e;

    function automatic int unsigned clamp_min(input int unsigned v, input int unsigned lo);
        return (v < lo) ? lo : v;
    endfunction

endpackage

// File: rtl/adc_ro_deser.sv
// rtl/adc_ro_deser.sv - N_CH x N_BITS bit-insert deserializer for the DIGOUT lanes
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         zero all channel words
//   sample      write din[c] into bit bit_idx of channel word c
//   bit_idx     bit position being converted (LSB first)
//   din         one serial bit per channel, channel 0 in the LSB
//   words       channel c at [c*N_BITS +: N_BITS]
module adc_ro_deser #(
    parameter int N_BITS = 12,
    parameter int N_CH   = 17,
    parameter int BIT_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     sample,
    input  logic [BIT_W-1:0]         bit_idx,
    input  logic [N_CH-1:0]          din,
    output logic [N_CH*N_BITS-1:0]   words
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words <= '0;
        end else if (clr) begin
            words <= '0;
        end else if (sample) begin
            for (int c = 0; c < N_CH; c++) begin
                words[c*N_BITS + int'(bit_idx)] <= din[c];
            end
        end
    end

endmodule

// File: rtl/adc_row_readout_ctrl.sv
// rtl/adc_row_readout_ctrl.sv - row latch / conversion strobe sequencer with DIGOUT deserializer
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      frame start pulse (ignored unless idle)
//   num_rows, ltch_cycles,
//   dv_hi_cycles, dv_lo_cycles frame config, latched at start (widths clamped to minimums)
//   RST_BAR_LTCHD              active-low row latch strobe
//   ADC_DATA_VALID             per-bit conversion strobe
//   DIGOUT                     bit-serial channel data, DIGOUT[1] = channel 0
//   row_data, row_idx,
//   row_valid, row_ready       completed-row handshake toward the host FIFO
//   busy, done                 frame in progress / end-of-frame pulse
//   chk_err_cnt                mismatching-row count from the pattern checker
// Build option: ADC_RO_CHECK_EN compiles in the test-pattern checker; otherwise
// chk_err_cnt is tied to zero.
module adc_row_readout_ctrl
    import adc_ro_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF,
    parameter int N_CH   = N_CH_DEF,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [15:0]              num_rows,
    input  logic [CNT_W-1:0]         ltch_cycles,
    input  logic [CNT_W-1:0]         dv_hi_cycles,
    input  logic [CNT_W-1:0]         dv_lo_cycles,
    output logic                     RST_BAR_LTCHD,
    output logic                     ADC_DATA_VALID,
    input  logic [N_CH:1]            DIGOUT,
    output logic [N_CH*N_BITS-1:0]   row_data,
    output logic [15:0]              row_idx,
    output logic                     row_valid,
    input  logic                     row_ready,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              chk_err_cnt
);

    localparam int BIT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(N_BITS - 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    ro_state_e             state, state_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_nx;
    logic [15:0]           row_cnt, row_cnt_nx;
    logic [15:0]           rows_q;
    logic [CNT_W-1:0]      ltch_q, hi_q, lo_q;
    logic [CNT_W-1:0]      ltch_in, hi_in, lo_in;
    logic                  cfg_load;
    logic                  handshake;
    logic                  sample;
    logic                  deser_clr;
    logic [N_CH*N_BITS-1:0] deser_words;

    assign ltch_in = CNT_W'(clamp_min(32'(ltch_cycles), LTCH_MIN));
    assign hi_in   = CNT_W'(clamp_min(32'(dv_hi_cycles), DV_HI_MIN));
    assign lo_in   = CNT_W'(clamp_min(32'(dv_lo_cycles), DV_LO_MIN));

    assign handshake = (state == S_PUSH) && row_valid && row_ready;
    // DIGOUT is captured at the end of the last high cycle of each bit.
    assign sample    = (state == S_DV_HI) && (cnt == '0);
    assign deser_clr = (state_nx == S_LATCH) && (state != S_LATCH);

    // cnt holds the remaining cycles of the current phase minus one.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt - ONE;
        bit_cnt_nx = bit_cnt;
        row_cnt_nx = row_cnt;
        cfg_load   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nx = cnt;
                if (start) begin
                    cfg_load   = 1'b1;
                    row_cnt_nx = '0;
                    if (num_rows == '0) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_LATCH;
                        cnt_nx   = ltch_in - ONE;
                    end
                end
            end
            S_LATCH: begin
                if (cnt == '0) begin
                    state_nx = S_GAP;
                    cnt_nx   = lo_q - ONE;
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_nx   = S_DV_HI;
                    cnt_nx     = hi_q - ONE;
                    bit_cnt_nx = '0;
                end
            end
            S_DV_HI: begin
                if (cnt == '0) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_nx = S_PUSH;
                        cnt_nx   = cnt;
                    end else begin
                        state_nx   = S_DV_LO;
                        cnt_nx     = lo_q - ONE;
                        bit_cnt_nx = bit_cnt + BIT_W'(1);
                    end
                end
            end
            S_DV_LO: begin
                if (cnt == '0) begin
                    state_nx = S_DV_HI;
                    cnt_nx   = hi_q - ONE;
                end
            end
            S_PUSH: begin
                cnt_nx = cnt;
                if (handshake) begin
                    row_cnt_nx = row_cnt + 16'd1;
                    if ((row_cnt + 16'd1) == rows_q) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_LATCH;
                        cnt_nx   = ltch_q - ONE;
                    end
                end
            end
            S_DONE: begin
                cnt_nx   = cnt;
                state_nx = S_IDLE;
            end
            default: begin
                cnt_nx   = cnt;
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            row_cnt <= '0;
            rows_q  <= '0;
            ltch_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_cnt <= bit_cnt_nx;
            row_cnt <= row_cnt_nx;
            if (cfg_load) begin
                rows_q <= num_rows;
                ltch_q <= ltch_in;
                hi_q   <= hi_in;
                lo_q   <= lo_in;
            end
        end
    end

    // Strobes and status are registered from the next state so they line up
    // with the state register without any combinational output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RST_BAR_LTCHD  <= 1'b1;
            ADC_DATA_VALID <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            RST_BAR_LTCHD  <= (state_nx != S_LATCH);
            ADC_DATA_VALID <= (state_nx == S_DV_HI);
            busy           <= (state_nx != S_IDLE) && (state_nx != S_DONE);
            done           <= (state_nx == S_DONE);
        end
    end

    // The first PUSH cycle copies the deserializer into the output register;
    // row_valid rises the cycle after, so row_data is frozen for the whole stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_valid <= 1'b0;
            row_data  <= '0;
            row_idx   <= '0;
        end else if ((state == S_PUSH) && !row_valid) begin
            row_valid <= 1'b1;
            row_data  <= deser_words;
            row_idx   <= row_cnt;
        end else if (handshake) begin
            row_valid <= 1'b0;
        end
    end

    adc_ro_deser #(
        .N_BITS (N_BITS),
        .N_CH   (N_CH),
        .BIT_W  (BIT_W)
    ) u_deser (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (deser_clr),
        .sample  (sample),
        .bit_idx (bit_cnt),
        .din     (DIGOUT),
        .words   (deser_words)
    );

`ifdef ADC_RO_CHECK_EN
    // Expected value follows the test-pattern generator's row address; it is
    // cleared only by reset so it keeps counting across frames.
    logic [N_BITS-1:0] chk_exp;
    logic [15:0]       err_q;
    logic              row_bad;

    always_comb begin
        row_bad = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (row_data[c*N_BITS +: N_BITS] != chk_exp) begin
                row_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_exp <= '0;
            err_q   <= '0;
        end else if (handshake) begin
            chk_exp <= chk_exp + N_BITS'(1);
            if (row_bad && (err_q != 16'hFFFF)) begin
                err_q <= err_q + 16'd1;
            end
        end
    end

    assign chk_err_cnt = err_q;
`else
    assign chk_err_cnt = '0;
`endif

endmodule

// File: doc/adc_row_readout_ctrl.md
# adc_row_readout_ctrl

Sequencer for the column-ADC readout interface. It drives the row-latch strobe (RST_BAR_LTCHD) and the per-bit conversion strobe (ADC_DATA_VALID) for a programmed number of rows. It deserializes the 17-channel bit-serial DIGOUT stream, LSB first, into one 12-bit word per channel. Each completed row goes to the host FIFO path over a valid/ready handshake. It sits between the host configuration registers and the sensor ADC pins, or the DIGOUT test-pattern generator in emulation builds.

## Interface
Parameters:
- N_BITS, 12, bits per conversion (serial length per row)
- N_CH, 17, DIGOUT channels
- CNT_W, 8, width of timing counters

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- start  in  1  single-cycle pulse; begins a frame (ignored while busy)
- num_rows  in  16  rows per frame; latched at start
- ltch_cycles  in  CNT_W  RST_BAR_LTCHD low width; latched at start; 0 treated as 1
- dv_hi_cycles  in  CNT_W  ADC_DATA_VALID high width; latched at start; values <2 treated as 2
- dv_lo_cycles  in  CNT_W  ADC_DATA_VALID low width; latched at start; 0 treated as 1
- RST_BAR_LTCHD  out  1  active-low row latch strobe
- ADC_DATA_VALID  out  1  per-bit conversion strobe
- DIGOUT  in  N_CH  serial data, bit [1] = channel 0
- row_data  out  N_CH*N_BITS  channel c at [c*N_BITS +: N_BITS]
- row_idx  out  16  row number of row_data, 0-based within frame
- row_valid  out  1  row_data/row_idx valid
- row_ready  in  1  downstream accepts when row_valid & row_ready
- busy  out  1  frame in progress
- done  out  1  single-cycle pulse at frame end
- chk_err_cnt  out  16  self-check mismatch count (see Configuration)

## Operation
- States: IDLE, LATCH, GAP, DV_HI, DV_LO, PUSH, DONE.
- IDLE: start=1 latches config, sets busy, clears row counter.
  - num_rows==0 → DONE directly.
  - Otherwise → LATCH.
- LATCH: RST_BAR_LTCHD=0 for ltch_cycles cycles → GAP.
- GAP: ADC_DATA_VALID=0 for dv_lo_cycles cycles → DV_HI.
- DV_HI: ADC_DATA_VALID=1 for dv_hi_cycles cycles. In the last cycle, DIGOUT is sampled and bit k is written into position k of each channel word, where k = bit counter 0..N_BITS-1.
  - After bit N_BITS-1 → PUSH.
  - Else → DV_LO.
- DV_LO: ADC_DATA_VALID=0 for dv_lo_cycles cycles → DV_HI.
- PUSH: row_valid=1; row_data and row_idx are held stable until the handshake. On the handshake, the row counter increments.
  - Rows remain → LATCH.
  - Else → DONE.
- DONE: done=1 for one cycle, busy=0 → IDLE.
- Stall: while in PUSH with row_ready=0, both strobes stay idle (RST_BAR_LTCHD=1, ADC_DATA_VALID=0) and no new row is latched.
- start while busy is ignored, with no effect on latched config.
- Channel words are cleared at LATCH entry.

## Timing
- Reset values: RST_BAR_LTCHD=1, ADC_DATA_VALID=0, row_valid=0, row_data=0, row_idx=0, busy=0, done=0, chk_err_cnt=0, state IDLE.
- All outputs are registered.
- Start accepted in cycle t: busy=1 and RST_BAR_LTCHD=0 from cycle t+1.
- Per row, the first row_valid cycle is L + N_BITS*(LO+HI) + 1 cycles after the first RST_BAR_LTCHD-low cycle, where L, LO and HI are the clamped widths.
- Handshake at cycle h: row_valid=0 at h+1.
  - Next row: RST_BAR_LTCHD=0 at h+1.
  - Last row: done=1 and busy=0 at h+1.
- Zero-row frame: done=1 at t+1, with no strobes.
- Asynchronous reset mid-frame: all outputs go to reset values immediately. The partial row is discarded and config must be re-issued via start.

## Configuration
- ADC_RO_CHECK_EN defined: a built-in pattern checker is compiled in.
  - It holds a 12-bit expected value, zeroed by rst_n only (not by start).
  - It compares every channel word of each row on handshake.
  - It increments chk_err_cnt by 1 per mismatching row (saturating at 0xFFFF).
  - The expected value increments after every row.
  - This matches the DIGOUT test-pattern generator, which serializes the row address, identical on all channels.
- Undefined: no checker logic; chk_err_cnt is tied to 0.

## Structure
- Shared package adc_ro_pkg holds:
  - the state enumeration (one-hot, 32-bit encoding as used elsewhere in the ADC blocks);
  - default N_BITS/N_CH;
  - the clamp minimums (LTCH_MIN=1, DV_HI_MIN=2, DV_LO_MIN=1).
- One sub-module: adc_ro_deser, an N_CH×N_BITS shift/insert register with clear, sample strobe and bit index.
- Sequencing, counters and checker stay in the top.

## Test plan
- num_rows=1, ltch=3, hi=2, lo=2, DIGOUT driven from test-pattern generator (pattern 0) → RST_BAR_LTCHD low exactly 3 cycles, 12 DV pulses of 2 high/2 low, row_valid after 52 cycles, all channels 0x000, done one cycle after handshake.
- num_rows=4, DIGOUT channel c held at constant bit pattern 0xA5C serialized LSB first → each row_data channel = 0xA5C, row_idx 0..3, single done.
- row_ready held low 20 cycles on row 1 of 3 → row_valid and data stable, no RST_BAR_LTCHD edge during stall, row 2 latch one cycle after handshake.
- num_rows=0 → done at t+1, no strobe toggles; start pulses during busy ignored.
- rst_n asserted during DV_HI of bit 5 → outputs at reset values same cycle; new start gives clean frame.
- ADC_RO_CHECK_EN with test-pattern generator, 5 rows → chk_err_cnt=0; flip one DIGOUT bit on row 2 → chk_err_cnt=1.
